// File: rtl/banco_solicitudes_pkg.sv
// Shared constants and helpers for the elevator request bank: how the
// up/down request bits of each floor are packed into the request vector.
package banco_solicitudes_pkg;

  localparam int IDX_SUBIR     = 0;
  localparam int IDX_BAJAR     = 1;
  localparam int BITS_POR_PISO = 2;

  // Bit index of a floor's up (IDX_SUBIR) or down (IDX_BAJAR) request
  function automatic int piso_bit(input int piso, input int dir);
    return piso * BITS_POR_PISO + dir;
  endfunction

endpackage

// File: rtl/banco_solicitudes_if.sv
// Bus between the elevator control logic (master) and the request bank
// (slave): button inputs, service/load/shift commands and state summaries.
interface banco_solicitudes_if #(
  parameter int PISOS = 5
);
  localparam int W  = 2 * PISOS;
  localparam int FW = $clog2(PISOS);
  localparam int CW = $clog2(W + 1);

  logic [W-1:0]     botones;
  logic             atender;
  logic [FW-1:0]    piso_atendido;
  logic             carga;
  logic [W-1:0]     entrada;
  logic             shift_en;
  logic             shift_dir;
  logic             shift_in;
  logic             shift_out;
  logic [W-1:0]     contenido;
  logic [PISOS-1:0] pendiente_piso;
  logic             hay_pendiente;
  logic [FW-1:0]    piso_max;
  logic [FW-1:0]    piso_min;
  logic [CW-1:0]    num_pendientes;

  modport master (
    output botones, atender, piso_atendido, carga, entrada,
           shift_en, shift_dir, shift_in,
    input  shift_out, contenido, pendiente_piso, hay_pendiente,
           piso_max, piso_min, num_pendientes
  );

  modport slave (
    input  botones, atender, piso_atendido, carga, entrada,
           shift_en, shift_dir, shift_in,
    output shift_out, contenido, pendiente_piso, hay_pendiente,
           piso_max, piso_min, num_pendientes
  );
endinterface

// File: rtl/codificador_pisos.sv
// Priority encoder over the per-floor pending vector. MSB_FIRST=1 yields the
// highest set floor, MSB_FIRST=0 the lowest. Returns 0 when nothing is set.
module codificador_pisos #(
  parameter int PISOS     = 5,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic [PISOS-1:0]         vec_i,
  output logic [$clog2(PISOS)-1:0] idx_o
);
  localparam int FW = $clog2(PISOS);

  if (MSB_FIRST) begin : g_msb
    // Ascending scan: the last set floor seen (highest) wins
    always_comb begin
      idx_o = '0;
      for (int i = 0; i < PISOS; i++) begin
        idx_o = vec_i[i] ? FW'(i) : idx_o;
      end
    end
  end else begin : g_lsb
    // Descending scan: the last set floor seen (lowest) wins
    always_comb begin
      idx_o = '0;
      for (int i = PISOS - 1; i >= 0; i--) begin
        idx_o = vec_i[i] ? FW'(i) : idx_o;
      end
    end
  end

endmodule

// File: rtl/banco_solicitudes.sv
// Elevator request register bank: latches button rising edges into one up
// and one down bit per floor, clears a served floor, supports parallel load
// and bidirectional serial shift, and publishes summaries of the held state.
module banco_solicitudes
  import banco_solicitudes_pkg::*;
#(
  parameter int PISOS = 5
) (
  input logic                clk,
  input logic                rst_n,
  banco_solicitudes_if.slave bus
);
  localparam int W  = 2 * PISOS;
  localparam int FW = $clog2(PISOS);
  localparam int CW = $clog2(W + 1);

  logic [W-1:0]     contenido_q;
  logic [W-1:0]     contenido_d;
  logic [W-1:0]     botones_q;
  logic [W-1:0]     rise_s;
  logic [W-1:0]     clr_mask_s;
  logic [PISOS-1:0] pendiente_s;
  logic [CW-1:0]    num_s;

  // A press is a button that is high now but was low last cycle
  assign rise_s = bus.botones & ~botones_q;

  // Clear mask: both bits of the served floor; an out-of-range floor matches nothing
  always_comb begin
    clr_mask_s = '0;
    for (int p = 0; p < PISOS; p++) begin
      clr_mask_s[piso_bit(p, IDX_SUBIR)] = bus.atender && (bus.piso_atendido == FW'(p));
      clr_mask_s[piso_bit(p, IDX_BAJAR)] = bus.atender && (bus.piso_atendido == FW'(p));
    end
  end

  // Next request state: load beats shift beats set/clear; set beats clear per bit
  always_comb begin
    contenido_d = contenido_q;
    if (bus.carga) begin
      contenido_d = bus.entrada;
    end else if (bus.shift_en) begin
      case (bus.shift_dir)
        1'b0:    contenido_d = {contenido_q[W-2:0], bus.shift_in};
        1'b1:    contenido_d = {bus.shift_in, contenido_q[W-1:1]};
        default: contenido_d = contenido_q;
      endcase
    end else begin
      contenido_d = (contenido_q & ~clr_mask_s) | rise_s;
    end
  end

  // Request and button-history registers; reset discards any pending operation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      contenido_q <= '0;
      botones_q   <= '0;
    end else begin
      contenido_q <= contenido_d;
      botones_q   <= bus.botones;
    end
  end

  // Per-floor pending flag: either direction requested
  always_comb begin
    pendiente_s = '0;
    for (int p = 0; p < PISOS; p++) begin
      pendiente_s[p] = contenido_q[piso_bit(p, IDX_SUBIR)] | contenido_q[piso_bit(p, IDX_BAJAR)];
    end
  end

  // Popcount of the request register
  always_comb begin
    num_s = '0;
    for (int i = 0; i < W; i++) begin
      num_s = num_s + CW'(contenido_q[i]);
    end
  end

  codificador_pisos #(.PISOS(PISOS), .MSB_FIRST(1'b1)) u_cod_max (
    .vec_i (pendiente_s),
    .idx_o (bus.piso_max)
  );

  codificador_pisos #(.PISOS(PISOS), .MSB_FIRST(1'b0)) u_cod_min (
    .vec_i (pendiente_s),
    .idx_o (bus.piso_min)
  );

  assign bus.contenido      = contenido_q;
  assign bus.pendiente_piso = pendiente_s;
  assign bus.hay_pendiente  = |contenido_q;
  assign bus.num_pendientes = num_s;
  assign bus.shift_out      = bus.shift_dir ? contenido_q[0] : contenido_q[W-1];

endmodule

// File: doc/banco_solicitudes.md
# banco_solicitudes

Parametrised elevator request register bank, successor to the fixed 5-floor request shift register. Holds one up bit and one down bit per floor. Latches button presses by rising-edge detection and clears a served floor on command. Keeps parallel load and serial shift, now bidirectional, and exposes registered-state summaries (per-floor pending, count, highest/lowest pending floor) to the elevator control FSM.

## Interface
- PISOS, 5, number of floors (≥2)
- W (localparam), 2*PISOS, request vector width
- FW (localparam), $clog2(PISOS), floor index width
- CW (localparam), $clog2(W+1), count width

- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- botones  in  W  button levels, synchronised upstream; bit 2i = floor i up, bit 2i+1 = floor i down
- atender  in  1  clear strobe for floor piso_atendido
- piso_atendido  in  FW  floor being served
- carga  in  1  parallel load
- entrada  in  W  parallel load value
- shift_en  in  1  shift one position
- shift_dir  in  1  0 = toward MSB (shift_in enters bit 0), 1 = toward LSB (shift_in enters bit W-1)
- shift_in  in  1  serial input
- shift_out  out  1  contenido[W-1] when shift_dir=0, contenido[0] when shift_dir=1
- contenido  out  W  request register
- pendiente_piso  out  PISOS  bit i = OR of floor i's two bits
- hay_pendiente  out  1  any bit set
- piso_max / piso_min  out  FW  highest / lowest pending floor, 0 when none
- num_pendientes  out  CW  popcount of contenido

## Operation
- Registers: contenido[W-1:0] and botones_q[W-1:0].
- rise = botones & ~botones_q. botones_q <= botones every cycle, including during carga and shift.
- Per-edge priority for contenido:
  1. carga: contenido <= entrada. Set and clear are ignored this cycle.
  2. else shift_en: shifted value per shift_dir. Set and clear are ignored this cycle.
  3. else: contenido <= (contenido & ~clr_mask) | rise.
- clr_mask covers bits 2p and 2p+1 when atender=1 and p=piso_atendido < PISOS. Otherwise it is 0.
- An out-of-range piso_atendido clears nothing.
- Set beats clear on the same bit in the same cycle, so a press during service is never lost.
- A button held high sets its bit once. It cannot re-set the bit until it is released and pressed again.
- Summary outputs are combinational functions of contenido only. They never depend on current inputs.

## Timing
- Press: botones bit low at edge k-1 and high at edge k gives the contenido bit set after edge k. Latency is 1 cycle.
- Clear, load and shift take effect at the edge where they are sampled. Latency is 1 cycle.
- Summaries are valid in the same cycle as contenido, with no extra latency.
- shift_out follows contenido and shift_dir combinationally.
- Reset: when rst_n=0, contenido=0 and botones_q=0 immediately, regardless of clk. All outputs are then 0: shift_out, pendiente_piso, hay_pendiente, piso_max, piso_min and num_pendientes.
- A button held through reset release registers as a press at the first edge after release.
- Reset mid-shift or mid-load discards the operation.

## Structure
- Package banco_solicitudes_pkg holds:
  - IDX_SUBIR=0, IDX_BAJAR=1
  - BITS_POR_PISO=2
  - function piso_bit(floor, dir) returning the bit index
- Sub-module codificador_pisos (parameter PISOS, optional MSB-first mode) is the priority encoder. It is instantiated twice, once for piso_max and once for piso_min, over pendiente_piso.
- The popcount lives inline as a for-loop in an always_comb.

## Test plan (PISOS=5, W=10)
- Reset: load 10'h3FF, then assert rst_n=0 between edges -> all outputs 0 before the next edge.
- Press: botones[6] rises and is held 5 cycles -> contenido=10'h040 after 1 edge and unchanged after. pendiente_piso=5'b01000, piso_max=piso_min=3, num_pendientes=1.
- Clear with simultaneous press, from 10'h0C0:
  - atender=1, piso_atendido=3, no edges -> contenido=10'h000.
  - Repeat from 10'h0C0 with botones[7] rising the same cycle -> 10'h080.
- Load and left shift: carga with entrada=10'h201 -> piso_max=4, piso_min=0, num_pendientes=2, shift_out=1. Then shift_en=1, shift_dir=0, shift_in=1 -> contenido=10'h003, shift_out=0.
- Right shift: from 10'h001 with shift_dir=1 -> shift_out=1. Shift with shift_in=1 -> contenido=10'h200.
- Priority and range:
  - carga=1 and shift_en=1 together with a button rise -> contenido=entrada.
  - atender=1 with piso_atendido=5 -> contenido unchanged.
